// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approx_mult_seq quadrant multiplier.
//   state_t     : FSM states IDLE / CALC / DONE
//   Q_LL..Q_HH  : quadrant indices (LL, A_H*B_L, A_L*B_H, HH)
//   quad_shift  : left shift applied to a quadrant product before accumulation
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] Q_LL = 2'd0;
    localparam logic [1:0] Q_HL = 2'd1;
    localparam logic [1:0] Q_LH = 2'd2;
    localparam logic [1:0] Q_HH = 2'd3;

    // Cross terms sit HALF bits up, the high-high term a full WIDTH up.
    function automatic int unsigned quad_shift(input logic [1:0] q, input int unsigned half);
        int unsigned sh;
        sh = 0;
        case (q)
            Q_LL:    sh = 0;
            Q_HL:    sh = half;
            Q_LH:    sh = half;
            Q_HH:    sh = 2 * half;
            default: sh = 0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/half_mult.sv
// Combinational HALF x HALF unsigned multiplier with optional low-bit truncation.
//   i_a, i_b  : HALF-bit operands
//   i_approx  : 1 -> zero the low TRUNC_BITS of the product
//   o_p       : 2*HALF-bit product
module half_mult #(
    parameter int unsigned HALF       = 4,
    parameter int unsigned TRUNC_BITS = 2
) (
    input  logic [HALF-1:0]   i_a,
    input  logic [HALF-1:0]   i_b,
    input  logic              i_approx,
    output logic [2*HALF-1:0] o_p
);

    localparam int unsigned PW = 2 * HALF;
    // All ones except the truncated low bits; all ones when TRUNC_BITS is 0.
    localparam logic [PW-1:0] TRUNC_MASK = ~PW'((64'd1 << TRUNC_BITS) - 64'd1);

    logic [PW-1:0] w_exact;

    assign w_exact = PW'(i_a) * PW'(i_b);
    assign o_p     = i_approx ? (w_exact & TRUNC_MASK) : w_exact;

endmodule

// File: rtl/approx_mult_seq.sv
// Time-multiplexed recursive multiplier: the four HALF x HALF quadrant products are
// computed one per cycle on a shared half_mult and shift-accumulated. Each quadrant
// may be approximated (low-bit truncation) via APPROX_MASK unless mode_exact is set.
// Ports: clk, rst (async, active-high), in_valid/in_ready/a/b/mode_exact (input side),
//        out_valid/out_ready/p (output side), err_cnt (only with APPROX_MULT_ERR_STATS_EN,
//        counts delivered products that differ from the exact product, saturating).
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [3:0]  APPROX_MASK = 4'b1000,
    parameter int unsigned TRUNC_BITS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
`ifdef APPROX_MULT_ERR_STATS_EN
    ,
    output logic [15:0]        err_cnt
`endif
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode_exact;
    logic [1:0]       r_q;
    logic [PW-1:0]    r_acc;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [HALF-1:0]  w_a_sel;
    logic [HALF-1:0]  w_b_sel;
    logic             w_approx;
    logic [WIDTH-1:0] w_sub;
    logic [PW-1:0]    w_addend;
    logic             w_accept;
    logic             w_deliver;

    // q[0] picks the high half of a, q[1] the high half of b.
    assign w_a_sel  = r_q[0] ? r_a[WIDTH-1:HALF] : r_a[HALF-1:0];
    assign w_b_sel  = r_q[1] ? r_b[WIDTH-1:HALF] : r_b[HALF-1:0];
    assign w_approx = ~r_mode_exact & APPROX_MASK[r_q];
    assign w_addend = PW'(w_sub) << quad_shift(r_q, HALF);

    assign w_accept  = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_deliver = (r_state == DONE) && r_out_valid && out_ready;

    half_mult #(
        .HALF       (HALF),
        .TRUNC_BITS (TRUNC_BITS)
    ) u_half_mult (
        .i_a      (w_a_sel),
        .i_b      (w_b_sel),
        .i_approx (w_approx),
        .o_p      (w_sub)
    );

    // FSM, operand capture and accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_mode_exact <= 1'b0;
            r_q          <= '0;
            r_acc        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_mode_exact <= mode_exact;
                        r_acc        <= '0;
                        r_q          <= '0;
                        r_in_ready   <= 1'b0;
                        r_state      <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= r_acc + w_addend;
                    r_q   <= r_q + 2'd1;
                    if (r_q == Q_HH) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (w_deliver) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_acc;

`ifdef APPROX_MULT_ERR_STATS_EN
    logic [PW-1:0] r_ref;
    logic [15:0]   r_err_cnt;

    // Exact reference captured at accept; compared on each delivered product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ref <= PW'(a) * PW'(b);
            end
            if (w_deliver && (r_acc != r_ref) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench for approx_mult_seq (WIDTH=8, APPROX_MASK=4'b1000, TRUNC_BITS=2).
// Directed corner cases followed by random operands against a quadrant-arithmetic model.
// Define APPROX_MULT_ERR_STATS_EN for both RTL and bench to also check err_cnt.
module tb_approx_mult_seq;

    localparam int unsigned WIDTH = 8;
    localparam logic [3:0]  MASK  = 4'b1000;
    localparam int unsigned TRUNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode_exact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
`ifdef APPROX_MULT_ERR_STATS_EN
    logic [15:0] err_cnt;
    int          exp_err;
`endif

    int n_pass;
    int n_total;

    approx_mult_seq #(
        .WIDTH       (WIDTH),
        .APPROX_MASK (MASK),
        .TRUNC_BITS  (TRUNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode_exact (mode_exact),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p)
`ifdef APPROX_MULT_ERR_STATS_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Sum of the four nibble products, truncating the quadrants marked in MASK.
    function automatic int model(input int x, input int y, input bit exact);
        int xs[4];
        int ys[4];
        int sh[4];
        int sum;
        int pr;
        xs = '{x % 16, x / 16, x % 16, x / 16};
        ys = '{y % 16, y % 16, y / 16, y / 16};
        sh = '{1, 16, 16, 256};
        sum = 0;
        for (int q = 0; q < 4; q++) begin
            pr = xs[q] * ys[q];
            if (!exact && MASK[q]) pr = (pr / (1 << TRUNC)) * (1 << TRUNC);
            sum += pr * sh[q];
        end
        return sum;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One full transaction: accept, latency/in_ready checks, backpressure hold, handshake.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input bit ex,
                         input int exp_p, input int hold);
        int lat;
        int wait_cnt;
        logic [15:0] p_first;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("in_ready_before_accept", int'(in_ready), 1);
        a = xa; b = xb; mode_exact = ex; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); mode_exact = ~ex;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("in_ready_low_calc", int'(in_ready), 0);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        chk("latency", lat, 5);
        chk("product", int'(p), exp_p);
        p_first = p;
        for (int i = 0; i < hold; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_p", int'(p), int'(p_first));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", int'(out_valid), 0);
        chk("ready_back", int'(in_ready), 1);
`ifdef APPROX_MULT_ERR_STATS_EN
        if (exp_p != int'(xa) * int'(xb)) exp_err++;
        chk("err_cnt", int'(err_cnt), exp_err);
`endif
    endtask

    initial begin
        int ra;
        int rb;
        bit rex;
        n_pass = 0; n_total = 0;
`ifdef APPROX_MULT_ERR_STATS_EN
        exp_err = 0;
`endif
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode_exact = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_p", int'(p), 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'hFF, 8'hFF, 1'b1, 65025, 0);
        do_op(8'hFF, 8'hFF, 1'b0, 64769, 1);
        do_op(8'h0F, 8'h0F, 1'b0, 225, 0);
        do_op(8'h10, 8'h10, 1'b0, 0, 10);
        do_op(8'h00, 8'hAB, 1'b0, 0, 0);

        // Reset pulsed while the quadrant counter is at 2.
        a = 8'hC3; b = 8'h5A; mode_exact = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_p", int'(p), 0);
        @(negedge clk);
        rst = 1'b0;
`ifdef APPROX_MULT_ERR_STATS_EN
        exp_err = 0;
        chk("midrst_err_cnt", int'(err_cnt), 0);
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_output", int'(out_valid), 0);
        end
        do_op(8'hC3, 8'h5A, 1'b1, 195 * 90, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = int'($urandom_range(0, 255));
            rb  = int'($urandom_range(0, 255));
            rex = 1'($urandom);
            do_op(8'(ra), 8'(rb), rex, model(ra, rb, rex), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
